// File: rtl/serial_nibble_adder.sv
// rtl/serial_nibble_adder.sv - wide add/sub computed one nibble per clock through a shared 4-bit stage
module serial_nibble_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            carry_r;
    logic [IW-1:0]   idx;
    logic [IW+1:0]   base;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [4:0]      nib_sum;
    logic            carry_into_msb;
    logic            last;
    logic            accept;

    // Status outputs are decoded straight from the state register.
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (idx == IW'(NIBBLES - 1));
    assign base   = {idx, 2'b00};

    // Shared 4-bit ripple stage working on the nibble selected by idx.
    always_comb begin
        a_nib          = a_r[base +: 4];
        b_nib          = b_r[base +: 4];
        nib_sum        = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
        carry_into_msb = nib_sum[3] ^ a_nib[3] ^ b_nib[3];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE accepts a new start just like IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at acceptance, then one result nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == RUN) begin
            sum[base +: 4] <= nib_sum[3:0];
            carry_r        <= nib_sum[4];
            if (last) begin
                cout <= nib_sum[4];
                ovf  <= carry_into_msb ^ nib_sum[4];
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (accept) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// tb/tb_serial_nibble_adder.sv - self-checking bench for serial_nibble_adder
module tb_serial_nibble_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic          cin;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int            n_checks;
    int            n_fail;
    logic [W-1:0]  exp_sum;
    logic          exp_cout;
    logic          exp_ovf;

    serial_nibble_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Whole-word arithmetic reference: a + (b or ~b) + carry-in, overflow from sign rule.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic msub, input logic mcin);
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb       = msub ? ~mb : mb;
        full     = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    endtask

    // Issue one operation from the current cycle; returns positioned in the DONE cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tsub, input logic tcin, input logic hold);
        start = 1'b1;
        a = ta;
        b = tb;
        sub = tsub;
        cin = tcin;
        model(ta, tb, tsub, tcin);
        @(posedge clk); #1;
        start = hold;
        for (int i = 1; i <= N; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            if (hold) begin
                a = W'($urandom);
                b = W'($urandom);
                sub = 1'($urandom);
                cin = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("sum", {16'd0, sum}, {16'd0, exp_sum});
        check("cout", {31'd0, cout}, {31'd0, exp_cout});
        check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_sum_hold", {16'd0, sum}, {16'd0, exp_sum});
        check("idle_cout_hold", {31'd0, cout}, {31'd0, exp_cout});
        check("idle_ovf_hold", {31'd0, ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 16'h1234;
        b     = 16'h0FFF;

        // Reset held with start asserted: nothing may start.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_sum", {16'd0, sum}, 32'd0);
            check("rst_cout", {31'd0, cout}, 32'd0);
            check("rst_ovf", {31'd0, ovf}, 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Directed cases.
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        check("add_expected_const", {16'd0, sum}, 32'h2233);
        idle_cycle();
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("carry_chain_const", {15'd0, cout, sum}, 32'h10000);
        idle_cycle();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("pos_ovf_const", {31'd0, ovf}, 32'd1);
        idle_cycle();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        check("sub_borrow_const", {15'd0, cout, sum}, 32'h0FFFE);
        idle_cycle();
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
        check("sub_ovf_const", {14'd0, ovf, cout, sum}, 32'h37FFF);
        idle_cycle();

        // Start held through RUN with changing operands, then back-to-back via DONE.
        run_op(16'hABCD, 16'h1357, 1'b0, 1'b1, 1'b1);
        run_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 1'b0);
        run_op(16'h4444, 16'h3333, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // Reset in the second RUN cycle abandons the operation.
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        sub = 1'b0;
        cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #1;
        check("midrst_idle_busy", {31'd0, busy}, 32'd0);
        check("midrst_idle_done", {31'd0, done}, 32'd0);
        run_op(16'h1111, 16'h2222, 1'b0, 1'b1, 1'b0);
        idle_cycle();

        // Randomized operations with random spacing and start holding.
        for (int k = 0; k < 24; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
